video_palette_mixer: RTL and testbench
======================================

// Module: video_palette_mixer
// PURPOSE
//  Pixel-domain colour stage between the game/graphics renderers and the hdmi encoder.
//  Maps an INDEX_W-bit colour index to COLOR_W-bit RGB through an MCU-writable palette.
//  Palette writes are double-buffered and committed at vertical blank, so no frame tears.
//  Has built-in test-pattern modes: border, colour bars and solid. Fixed 2-cycle pipeline.
// PARAMETERS
//  INDEX_W     3     colour index width, >=3; palette has 2**INDEX_W entries
//  COLOR_W     24    RGB width, multiple of 3, {R,G,B} MSB first
//  COORD_W     10    width of cx/cy
//  SCREEN_W    640   active width in pixels
//  SCREEN_H    480   active height in lines
//  VBL_COMMIT  1     1 = commit shadow palette at vblank; 0 = commit on the cycle after a write
// PORTS
//  clk_pixel     in   1        pixel clock; the only clock
//  reset         in   1        synchronous, active-high
//  cx, cy        in   COORD_W  current pixel coordinate from hdmi
//  pix_on        in   1        renderer pixel valid (graph_on)
//  pix_index     in   INDEX_W  renderer colour index
//  mode          in   2        0=palette 1=border 2=bars 3=solid
//  solid_rgb     in   COLOR_W  colour for mode 3
//  pal_wr_valid  in   1        palette write request
//  pal_wr_ready  out  1        palette write accept
//  pal_wr_addr   in   INDEX_W  palette entry to write
//  pal_wr_data   in   COLOR_W  new entry value
//  rgb           out  COLOR_W  output colour, 2 cycles after cx/cy
//  out_cx,out_cy out  COORD_W  cx/cy delayed 2 cycles, aligned with rgb
//  mode_active   out  2        mode currently in effect
//  frame_cnt     out  16       count of frame starts, wraps
//  pal_dirty     out  1        shadow holds uncommitted writes
// BEHAVIOUR
//  Reset (sync, active-high; may assert mid-frame):
//   - rgb, out_cx, out_cy, frame_cnt, mode_active, pal_dirty = 0.
//   - Both palette banks reload defaults on the same cycle.
//   - Pipeline contents discarded. rgb stays 0 for 2 cycles after reset deasserts.
//   - pal_wr_ready = 0 while reset is high, 1 otherwise.
//  Default entry i: R/G/B = all-ones if bit i[INDEX_W-1]/i[INDEX_W-2]/i[INDEX_W-3] set, else 0.
//   INDEX_W=3 gives 7=ffffff 6=ffff00 5=ff00ff 4=ff0000 3=00ffff 2=00ff00 1=0000ff 0=000000.
//  Palette write: accepted when pal_wr_valid & pal_wr_ready; the data goes to the shadow bank.
//   - The accepting cycle sets pal_dirty.
//   - Same-address writes: the last one wins.
//  Commit (VBL_COMMIT=1): on a cycle with cx==0, cy==SCREEN_H and pal_dirty=1:
//   - Copy shadow to active and clear pal_dirty.
//   - A write accepted on the commit cycle is not copied; pal_dirty stays 1 and it commits next vblank.
//   - If SCREEN_H is never reached, no commit happens.
//  Commit (VBL_COMMIT=0): an accepted write reaches the active bank one cycle later; pal_dirty pulses for 1 cycle.
//  Frame start = cycle with cx==0 and cy==0. On it:
//   - mode_active <= mode.
//   - frame_cnt increments, 16'hffff wraps to 0.
//   - Mode changes mid-frame have no effect until the next frame start.
//  Stage 1 registers coordinate, active mode and colour select. Stage 2 registers rgb.
//  Total latency is exactly 2 cycles, with a new pixel every cycle.
//  Colour select, in priority order:
//   1. cx>=SCREEN_W or cy>=SCREEN_H -> 0 in every mode.
//   2. mode 0 -> active[pix_index] if pix_on, else active[0].
//   3. mode 1 -> cx==0 red; else cy==0 green; else cx==SCREEN_W-1 or cy==SCREEN_H-1 blue; else 0.
//   4. mode 2 -> bar k = floor(cx*8/SCREEN_W); colour = default entry 7-k
//      (white, yellow, magenta, red, cyan, green, blue, black). Computed by constant comparisons, no divider.
//   5. mode 3 -> solid_rgb, sampled in stage 1.
//  Full-scale channel = all-ones of COLOR_W/3 bits.
// TESTING
//  1. Release reset, mode=0, pix_on=1, index 6 at (10,10) -> rgb=ffff00, out_cx=10, out_cy=10 two cycles later.
//  2. Write addr 4 = 123456 at cy=100:
//     - pal_dirty=1 and index 4 still gives ff0000 for the rest of the frame.
//     - (0,480) commits; index 4 then gives 123456 and pal_dirty=0.
//  3. Set mode=1 mid-frame; mode_active changes only at (0,0). Then:
//     (0,5)->ff0000, (5,0)->00ff00, (639,5)->0000ff, (5,479)->0000ff, (5,5)->000000.
//  4. Mode 2: cx=0->ffffff, 79->ffffff, 80->ffff00, 639->000000. Mode 3, solid_rgb=abcdef -> abcdef.
//  5. Out of screen and counters:
//     - (700,10) and (10,500) -> 0 in every mode.
//     - Preload frame_cnt=ffff via frame starts; next (0,0) -> 0.
//  6. Write at the commit cycle -> pal_dirty stays 1, committed next vblank.
//     Reset mid-frame after writes -> defaults restored, rgb=0 for 2 cycles.

Source files
------------

// File: rtl/video_palette_mixer_if.sv
// Pixel, palette-write and status signals between the renderers/MCU and the palette mixer.
interface video_palette_mixer_if #(
    parameter int unsigned INDEX_W = 3,
    parameter int unsigned COLOR_W = 24,
    parameter int unsigned COORD_W = 10
);
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
    logic               pix_on;
    logic [INDEX_W-1:0] pix_index;
    logic [1:0]         mode;
    logic [COLOR_W-1:0] solid_rgb;
    logic               pal_wr_valid;
    logic               pal_wr_ready;
    logic [INDEX_W-1:0] pal_wr_addr;
    logic [COLOR_W-1:0] pal_wr_data;
    logic [COLOR_W-1:0] rgb;
    logic [COORD_W-1:0] out_cx;
    logic [COORD_W-1:0] out_cy;
    logic [1:0]         mode_active;
    logic [15:0]        frame_cnt;
    logic               pal_dirty;

    modport master (
        output cx, cy, pix_on, pix_index, mode, solid_rgb,
               pal_wr_valid, pal_wr_addr, pal_wr_data,
        input  pal_wr_ready, rgb, out_cx, out_cy, mode_active, frame_cnt, pal_dirty
    );

    modport slave (
        input  cx, cy, pix_on, pix_index, mode, solid_rgb,
               pal_wr_valid, pal_wr_addr, pal_wr_data,
        output pal_wr_ready, rgb, out_cx, out_cy, mode_active, frame_cnt, pal_dirty
    );
endinterface

// File: rtl/video_palette_mixer.sv
// Index-to-RGB colour stage with a vblank-committed double-buffered palette and test patterns.
// Two-stage pipeline: stage 1 picks the colour source, stage 2 produces rgb.
module video_palette_mixer #(
    parameter int unsigned INDEX_W    = 3,
    parameter int unsigned COLOR_W    = 24,
    parameter int unsigned COORD_W    = 10,
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned VBL_COMMIT = 1
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    video_palette_mixer_if.slave  bus
);

    localparam int unsigned ENTRIES = 1 << INDEX_W;
    localparam int unsigned CH_W    = COLOR_W / 3;
    localparam bit          VBL     = (VBL_COMMIT != 0);

    // Expand a 3-bit {R,G,B} on/off code to full-scale channels.
    function automatic logic [COLOR_W-1:0] rgb_of(input logic [2:0] b);
        return {{CH_W{b[2]}}, {CH_W{b[1]}}, {CH_W{b[0]}}};
    endfunction

    function automatic logic [COLOR_W-1:0] def_entry(input int unsigned i);
        logic [INDEX_W-1:0] idx;
        idx = INDEX_W'(i);
        return rgb_of(idx[INDEX_W-1 -: 3]);
    endfunction

    // Bar number floor(x*8/SCREEN_W) from constant thresholds ceil(j*SCREEN_W/8).
    function automatic logic [2:0] bar_k(input logic [COORD_W-1:0] x);
        logic [2:0] k;
        k = '0;
        for (int unsigned j = 1; j < 8; j++) begin
            if (32'(x) >= (j * SCREEN_W + 7) / 8) k = 3'(j);
        end
        return k;
    endfunction

    logic [COLOR_W-1:0] active [ENTRIES];
    logic [COLOR_W-1:0] shadow [ENTRIES];
    logic               dirty_q;
    logic [1:0]         mode_q;
    logic [15:0]        fc_q;

    logic               s1_pal;
    logic [INDEX_W-1:0] s1_idx;
    logic [COLOR_W-1:0] s1_color;
    logic [COORD_W-1:0] s1_cx, s1_cy;

    logic [COLOR_W-1:0] rgb_q;
    logic [COORD_W-1:0] ocx_q, ocy_q;

    logic               wr_fire_c, frame_start_c, commit_c, off_screen_c;
    logic [1:0]         eff_mode_c;
    logic [31:0]        x32_c, y32_c;
    logic               sel_pal_c;
    logic [INDEX_W-1:0] sel_idx_c;
    logic [COLOR_W-1:0] sel_color_c;

    assign bus.pal_wr_ready = ~reset;
    assign bus.rgb          = rgb_q;
    assign bus.out_cx       = ocx_q;
    assign bus.out_cy       = ocy_q;
    assign bus.mode_active  = mode_q;
    assign bus.frame_cnt    = fc_q;
    assign bus.pal_dirty    = dirty_q;

    // Control decode and stage-1 colour select; the frame-start pixel already uses the new mode.
    always_comb begin
        x32_c         = 32'(bus.cx);
        y32_c         = 32'(bus.cy);
        wr_fire_c     = bus.pal_wr_valid & bus.pal_wr_ready;
        frame_start_c = (bus.cx == '0) && (bus.cy == '0);
        commit_c      = VBL ? ((bus.cx == '0) && (y32_c == SCREEN_H) && dirty_q) : dirty_q;
        off_screen_c  = (x32_c >= SCREEN_W) || (y32_c >= SCREEN_H);
        eff_mode_c    = frame_start_c ? bus.mode : mode_q;
        sel_pal_c     = 1'b0;
        sel_idx_c     = '0;
        sel_color_c   = '0;
        if (!off_screen_c) begin
            case (eff_mode_c)
                2'd0: begin
                    sel_pal_c = 1'b1;
                    sel_idx_c = bus.pix_on ? bus.pix_index : '0;
                end
                2'd1: begin
                    if (bus.cx == '0)       sel_color_c = rgb_of(3'b100);
                    else if (bus.cy == '0)  sel_color_c = rgb_of(3'b010);
                    else if ((x32_c == SCREEN_W - 1) || (y32_c == SCREEN_H - 1))
                                            sel_color_c = rgb_of(3'b001);
                end
                2'd2:    sel_color_c = rgb_of(3'd7 - bar_k(bus.cx));
                default: sel_color_c = bus.solid_rgb;
            endcase
        end
    end

    // Palette banks: writes land in shadow, commit copies the pre-write shadow into active.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                active[i] <= def_entry(i);
                shadow[i] <= def_entry(i);
            end
            dirty_q <= 1'b0;
        end else begin
            if (commit_c) begin
                for (int unsigned i = 0; i < ENTRIES; i++) active[i] <= shadow[i];
            end
            if (wr_fire_c) shadow[bus.pal_wr_addr] <= bus.pal_wr_data;
            dirty_q <= wr_fire_c | (dirty_q & ~commit_c);
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            mode_q <= 2'd0;
            fc_q   <= 16'd0;
        end else if (frame_start_c) begin
            mode_q <= bus.mode;
            fc_q   <= fc_q + 16'd1;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            s1_pal   <= 1'b0;
            s1_idx   <= '0;
            s1_color <= '0;
            s1_cx    <= '0;
            s1_cy    <= '0;
            rgb_q    <= '0;
            ocx_q    <= '0;
            ocy_q    <= '0;
        end else begin
            s1_pal   <= sel_pal_c;
            s1_idx   <= sel_idx_c;
            s1_color <= sel_color_c;
            s1_cx    <= bus.cx;
            s1_cy    <= bus.cy;
            rgb_q    <= s1_pal ? active[s1_idx] : s1_color;
            ocx_q    <= s1_cx;
            ocy_q    <= s1_cy;
        end
    end

endmodule

// File: tb/tb_video_palette_mixer.sv
// Directed bench for video_palette_mixer: expected pixels are queued at drive time and
// compared by a monitor when they emerge two cycles later.
module tb_video_palette_mixer;

    localparam int unsigned INDEX_W = 3;
    localparam int unsigned COLOR_W = 24;
    localparam int unsigned COORD_W = 10;

    typedef struct {
        logic [23:0] rgb;
        logic [9:0]  cx;
        logic [9:0]  cy;
        int          tx;
        int          ty;
    } exp_t;

    logic        clk_pixel = 1'b0;
    logic        reset     = 1'b1;
    logic        chk_in    = 1'b0;
    logic        chk_d1    = 1'b0;
    logic        chk_d2    = 1'b0;
    logic [15:0] exp_fc    = 16'd0;
    int          checks    = 0;
    int          errors    = 0;
    exp_t        sb[$];
    exp_t        mon_e;

    always #5 clk_pixel = ~clk_pixel;

    video_palette_mixer_if #(.INDEX_W(INDEX_W), .COLOR_W(COLOR_W), .COORD_W(COORD_W)) bus ();

    video_palette_mixer #(
        .INDEX_W(INDEX_W), .COLOR_W(COLOR_W), .COORD_W(COORD_W),
        .SCREEN_W(640), .SCREEN_H(480), .VBL_COMMIT(1)
    ) dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .bus       (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Marks pixels whose result is expected two cycles later.
    always @(posedge clk_pixel) begin
        chk_d1 <= chk_in;
        chk_d2 <= chk_d1;
    end

    always @(negedge clk_pixel) begin
        if (chk_d2) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: output at (%0d,%0d) with nothing expected",
                         bus.out_cx, bus.out_cy);
            end else begin
                mon_e = sb.pop_front();
                if ({bus.rgb, bus.out_cx, bus.out_cy} !== {mon_e.rgb, mon_e.cx, mon_e.cy}) begin
                    errors++;
                    $display("FAIL pix(%0d,%0d): rgb/cx/cy got %h/%0d/%0d expected %h/%0d/%0d",
                             mon_e.tx, mon_e.ty, bus.rgb, bus.out_cx, bus.out_cy,
                             mon_e.rgb, mon_e.cx, mon_e.cy);
                end
            end
        end
    end

    task automatic drive(input int x, input int y, input logic [2:0] idx, input logic on,
                         input logic chk, input logic [23:0] exp, input logic [9:0] ecx,
                         input logic [9:0] ecy);
        exp_t e;
        bus.cx        = 10'(x);
        bus.cy        = 10'(y);
        bus.pix_index = idx;
        bus.pix_on    = on;
        chk_in        = chk;
        if (chk) begin
            e.rgb = exp; e.cx = ecx; e.cy = ecy; e.tx = x; e.ty = y;
            sb.push_back(e);
        end
        if (reset) exp_fc = 16'd0;
        else if (x == 0 && y == 0) exp_fc = exp_fc + 16'd1;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic [2:0] idx, input logic on,
                       input logic chk, input logic [23:0] exp);
        drive(x, y, idx, on, chk, exp, 10'(x), 10'(y));
    endtask

    task automatic wpix(input logic [2:0] addr, input logic [23:0] data, input int x, input int y,
                        input logic [2:0] idx, input logic on, input logic chk, input logic [23:0] exp);
        bus.pal_wr_valid = 1'b1;
        bus.pal_wr_addr  = addr;
        bus.pal_wr_data  = data;
        pix(x, y, idx, on, chk, exp);
        bus.pal_wr_valid = 1'b0;
    endtask

    initial begin
        bus.cx = 10'd1; bus.cy = 10'd1; bus.pix_on = 1'b0; bus.pix_index = 3'd0;
        bus.mode = 2'd0; bus.solid_rgb = 24'h0; bus.pal_wr_valid = 1'b0;
        bus.pal_wr_addr = 3'd0; bus.pal_wr_data = 24'h0;
        reset = 1'b1;
        repeat (3) @(posedge clk_pixel);
        #1;
        check("reset_rgb", 32'(bus.rgb), 32'h0);
        check("reset_out_cx", 32'(bus.out_cx), 32'h0);
        check("reset_frame_cnt", 32'(bus.frame_cnt), 32'h0);
        check("reset_mode_active", 32'(bus.mode_active), 32'h0);
        check("reset_pal_dirty", 32'(bus.pal_dirty), 32'h0);
        check("reset_wr_ready", 32'(bus.pal_wr_ready), 32'h0);
        reset = 1'b0;
        #1;
        check("wr_ready_after_reset", 32'(bus.pal_wr_ready), 32'h1);

        // Palette defaults and off-screen blanking in mode 0.
        pix(10, 10, 3'd6, 1'b1, 1'b1, 24'hffff00);
        pix(11, 10, 3'd5, 1'b0, 1'b1, 24'h000000);
        pix(12, 10, 3'd3, 1'b1, 1'b1, 24'h00ffff);
        pix(700, 10, 3'd7, 1'b1, 1'b1, 24'h000000);
        pix(10, 500, 3'd7, 1'b1, 1'b1, 24'h000000);

        // Shadow write, visible only after the vblank commit.
        wpix(3'd4, 24'h123456, 5, 100, 3'd4, 1'b1, 1'b1, 24'hff0000);
        check("dirty_after_write", 32'(bus.pal_dirty), 32'h1);
        pix(20, 200, 3'd4, 1'b1, 1'b1, 24'hff0000);
        pix(0, 480, 3'd4, 1'b1, 1'b1, 24'h000000);
        check("dirty_after_commit", 32'(bus.pal_dirty), 32'h0);
        pix(30, 30, 3'd4, 1'b1, 1'b1, 24'h123456);

        // Border mode, taking effect only at frame start.
        bus.mode = 2'd1;
        pix(40, 40, 3'd4, 1'b1, 1'b1, 24'h123456);
        check("mode_hold_midframe", 32'(bus.mode_active), 32'h0);
        pix(0, 0, 3'd0, 1'b0, 1'b0, 24'h0);
        check("mode_border", 32'(bus.mode_active), 32'h1);
        check("frame_cnt_1", 32'(bus.frame_cnt), 32'(exp_fc));
        pix(0, 5, 3'd0, 1'b0, 1'b1, 24'hff0000);
        pix(5, 0, 3'd0, 1'b0, 1'b1, 24'h00ff00);
        pix(639, 5, 3'd0, 1'b0, 1'b1, 24'h0000ff);
        pix(5, 479, 3'd0, 1'b0, 1'b1, 24'h0000ff);
        pix(5, 5, 3'd0, 1'b0, 1'b1, 24'h000000);

        // Colour bars.
        bus.mode = 2'd2;
        pix(0, 0, 3'd0, 1'b0, 1'b0, 24'h0);
        check("mode_bars", 32'(bus.mode_active), 32'h2);
        pix(0, 5, 3'd0, 1'b0, 1'b1, 24'hffffff);
        pix(79, 5, 3'd0, 1'b0, 1'b1, 24'hffffff);
        pix(80, 5, 3'd0, 1'b0, 1'b1, 24'hffff00);
        pix(320, 5, 3'd0, 1'b0, 1'b1, 24'h00ffff);
        pix(639, 5, 3'd0, 1'b0, 1'b1, 24'h000000);
        pix(700, 10, 3'd0, 1'b0, 1'b1, 24'h000000);
        pix(10, 500, 3'd0, 1'b0, 1'b1, 24'h000000);

        // Solid colour, plus a mid-frame mode change that must be ignored.
        bus.mode = 2'd3;
        bus.solid_rgb = 24'habcdef;
        pix(0, 0, 3'd0, 1'b0, 1'b0, 24'h0);
        check("mode_solid", 32'(bus.mode_active), 32'h3);
        pix(100, 100, 3'd0, 1'b0, 1'b1, 24'habcdef);
        pix(700, 10, 3'd0, 1'b0, 1'b1, 24'h000000);
        pix(10, 500, 3'd0, 1'b0, 1'b1, 24'h000000);
        bus.mode = 2'd0;
        pix(200, 100, 3'd2, 1'b1, 1'b1, 24'habcdef);
        check("mode_solid_hold", 32'(bus.mode_active), 32'h3);
        pix(0, 0, 3'd0, 1'b0, 1'b0, 24'h0);

        // A write on the commit cycle waits for the following vblank.
        wpix(3'd2, 24'h654321, 50, 50, 3'd2, 1'b1, 1'b1, 24'h00ff00);
        check("dirty_write2", 32'(bus.pal_dirty), 32'h1);
        wpix(3'd5, 24'h0f0f0f, 0, 480, 3'd0, 1'b0, 1'b1, 24'h000000);
        check("dirty_commit_cycle_write", 32'(bus.pal_dirty), 32'h1);
        pix(60, 60, 3'd2, 1'b1, 1'b1, 24'h654321);
        pix(61, 60, 3'd5, 1'b1, 1'b1, 24'hff00ff);
        pix(0, 480, 3'd0, 1'b0, 1'b1, 24'h000000);
        check("dirty_second_commit", 32'(bus.pal_dirty), 32'h0);
        pix(62, 60, 3'd5, 1'b1, 1'b1, 24'h0f0f0f);

        // Frame counter wrap.
        check("frame_cnt_progress", 32'(bus.frame_cnt), 32'(exp_fc));
        while (exp_fc != 16'hffff) pix(0, 0, 3'd0, 1'b0, 1'b0, 24'h0);
        check("frame_cnt_ffff", 32'(bus.frame_cnt), 32'h0000ffff);
        pix(0, 0, 3'd0, 1'b0, 1'b0, 24'h0);
        check("frame_cnt_wrap", 32'(bus.frame_cnt), 32'h0);

        // Reset mid-frame with a pending write and a committed custom entry.
        bus.mode = 2'd2;
        pix(0, 0, 3'd0, 1'b0, 1'b0, 24'h0);
        wpix(3'd6, 24'h777777, 80, 80, 3'd6, 1'b1, 1'b1, 24'hffff00);
        check("dirty_before_reset", 32'(bus.pal_dirty), 32'h1);
        pix(81, 80, 3'd0, 1'b0, 1'b0, 24'h0);
        reset = 1'b1;
        drive(10, 10, 3'd7, 1'b1, 1'b1, 24'h0, 10'd0, 10'd0);
        drive(10, 10, 3'd7, 1'b1, 1'b1, 24'h0, 10'd0, 10'd0);
        drive(10, 10, 3'd7, 1'b1, 1'b1, 24'h0, 10'd0, 10'd0);
        check("midreset_wr_ready", 32'(bus.pal_wr_ready), 32'h0);
        check("midreset_dirty", 32'(bus.pal_dirty), 32'h0);
        check("midreset_mode", 32'(bus.mode_active), 32'h0);
        check("midreset_frame_cnt", 32'(bus.frame_cnt), 32'h0);
        reset = 1'b0;
        pix(10, 10, 3'd1, 1'b1, 1'b1, 24'h0000ff);
        pix(11, 10, 3'd4, 1'b1, 1'b1, 24'hff0000);
        pix(0, 480, 3'd0, 1'b0, 1'b1, 24'h000000);
        pix(12, 10, 3'd6, 1'b1, 1'b1, 24'hffff00);
        check("dirty_after_reset", 32'(bus.pal_dirty), 32'h0);

        chk_in = 1'b0;
        repeat (4) @(posedge clk_pixel);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
